// File: rtl/isqrt_result_checker.sv
// Self-check for the inverse-square-root core: recomputes x*y^2 and flags
// results that land farther than TOL LSBs from 1.0.
module isqrt_result_checker #(
    parameter int XW   = 23,
    parameter int YW   = 27,
    parameter int FRAC = 23,
    parameter int TOL  = 8388,
    parameter int CW   = 16
) (
    input  logic          clk_p,
    input  logic          reset,
    input  logic [XW-1:0] x_in,
    input  logic [YW-1:0] y_in,
    input  logic          ready_in,
    output logic [YW-1:0] prod_out,
    output logic          err_out,
    output logic          valid_out,
    output logic          busy_out,
    output logic          overrun_out,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt
);

    localparam int PW = 2*YW - FRAC;
    localparam int MW = YW + PW;
    localparam logic [YW-1:0] ONE   = YW'(1) << FRAC;
    localparam logic [YW-1:0] TOL_W = YW'(TOL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL1,
        S_MUL2,
        S_CMP
    } state_t;

    state_t        r_state;
    logic          r_ready_prev;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [PW-1:0] r_p;
    logic [YW-1:0] r_e;

    logic          w_rise;
    logic          w_mul2;
    logic [YW-1:0] w_mul_a;
    logic [PW-1:0] w_mul_b;
    logic [MW-1:0] w_prod;
    logic          w_sat;
    logic [YW-1:0] w_e;
    logic [YW-1:0] w_diff;
    logic          w_xzero;
    logic          w_fail;
    logic          w_unused;

    assign w_rise = ready_in & ~r_ready_prev;
    assign w_mul2 = (r_state == S_MUL2);

    // Shared multiplier; B is widened so it can carry the Q8.23 square.
    assign w_mul_a = w_mul2 ? {{(YW-XW){1'b0}}, r_x} : r_y;
    assign w_mul_b = w_mul2 ? r_p : {{(PW-YW){1'b0}}, r_y};
    assign w_prod  = {{PW{1'b0}}, w_mul_a} * {{YW{1'b0}}, w_mul_b};

    assign w_sat = |w_prod[MW-1:FRAC+YW];
    assign w_e   = w_sat ? {YW{1'b1}} : w_prod[FRAC+YW-1:FRAC];

    assign w_diff  = (r_e >= ONE) ? (r_e - ONE) : (ONE - r_e);
    assign w_xzero = (r_x == '0);
    assign w_fail  = (w_diff > TOL_W) | w_xzero;

    assign busy_out = (r_state != S_IDLE);
    assign w_unused = &{1'b0, w_prod[FRAC-1:0]};

    always_ff @(posedge clk_p) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ready_prev <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_p          <= '0;
            r_e          <= '0;
            prod_out     <= '0;
            err_out      <= 1'b0;
            valid_out    <= 1'b0;
            overrun_out  <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
        end else begin
            r_ready_prev <= ready_in;
            valid_out    <= 1'b0;
            if (w_rise && r_state != S_IDLE)
                overrun_out <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_x     <= x_in;
                        r_y     <= y_in;
                        r_state <= S_MUL1;
                    end
                end
                S_MUL1: begin
                    r_p     <= w_prod[2*YW-1:FRAC];
                    r_state <= S_MUL2;
                end
                S_MUL2: begin
                    r_e     <= w_e;
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    prod_out  <= w_xzero ? '0 : r_e;
                    err_out   <= w_fail;
                    valid_out <= 1'b1;
                    if (w_fail) begin
                        if (!(&fail_cnt))
                            fail_cnt <= fail_cnt + 1'b1;
                    end else begin
                        if (!(&pass_cnt))
                            pass_cnt <= pass_cnt + 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_isqrt_result_checker.sv
// Scoreboard bench for isqrt_result_checker: directed vectors, queued
// expectations, and a monitor that pops on every valid_out.
module tb_isqrt_result_checker;

    logic        clk_p = 1'b0;
    logic        reset = 1'b1;
    logic [22:0] x_in = '0;
    logic [26:0] y_in = '0;
    logic        ready_in = 1'b0;

    logic [26:0] prod_out, prod_a, prod_b;
    logic        err_out, err_a, err_b;
    logic        valid_out, valid_a, valid_b;
    logic        busy_out, busy_a, busy_b;
    logic        overrun_out, ovr_a, ovr_b;
    logic [15:0] pass_cnt, fail_cnt, pass_a, fail_a;
    logic [1:0]  pass_b, fail_b;

    always #5 clk_p = ~clk_p;

    isqrt_result_checker u_dut (
        .clk_p(clk_p), .reset(reset), .x_in(x_in), .y_in(y_in),
        .ready_in(ready_in), .prod_out(prod_out), .err_out(err_out),
        .valid_out(valid_out), .busy_out(busy_out),
        .overrun_out(overrun_out), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    isqrt_result_checker #(.TOL(4194304)) u_a (
        .clk_p(clk_p), .reset(reset), .x_in(x_in), .y_in(y_in),
        .ready_in(ready_in), .prod_out(prod_a), .err_out(err_a),
        .valid_out(valid_a), .busy_out(busy_a),
        .overrun_out(ovr_a), .pass_cnt(pass_a), .fail_cnt(fail_a)
    );

    isqrt_result_checker #(.TOL(4194303), .CW(2)) u_b (
        .clk_p(clk_p), .reset(reset), .x_in(x_in), .y_in(y_in),
        .ready_in(ready_in), .prod_out(prod_b), .err_out(err_b),
        .valid_out(valid_b), .busy_out(busy_b),
        .overrun_out(ovr_b), .pass_cnt(pass_b), .fail_cnt(fail_b)
    );

    typedef struct {
        logic [26:0] prod;
        logic        err;
        logic [22:0] x;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcnt = 0;
    int pass_exp = 0;
    int fail_exp = 0;
    int failb_exp = 0;

    always @(posedge clk_p) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic tol_err(input logic [26:0] p,
                                     input logic [22:0] x, input int tol);
        int d;
        d = (int'(p) >= 8388608) ? int'(p) - 8388608 : 8388608 - int'(p);
        return (d > tol) || (x == 0);
    endfunction

    always @(negedge clk_p) begin
        exp_t it;
        if (valid_out) begin
            vcnt++;
            if (q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                it = q.pop_front();
                if (it.err) fail_exp++;
                else pass_exp++;
                chk("prod_out", 32'(prod_out), 32'(it.prod));
                chk("err_out", 32'(err_out), 32'(it.err));
                chk("latency_cyc", cyc, it.cyc);
                chk("pass_cnt", 32'(pass_cnt), pass_exp);
                chk("fail_cnt", 32'(fail_cnt), fail_exp);
            end
        end
        if (valid_a) begin
            if (qa.size() == 0) begin
                chk("unexpected_valid_a", 32'd1, 32'd0);
            end else begin
                it = qa.pop_front();
                chk("err_tolA", 32'(err_a),
                    32'(tol_err(it.prod, it.x, 4194304)));
            end
        end
        if (valid_b) begin
            if (qb.size() == 0) begin
                chk("unexpected_valid_b", 32'd1, 32'd0);
            end else begin
                it = qb.pop_front();
                if (tol_err(it.prod, it.x, 4194303))
                    failb_exp = (failb_exp == 3) ? 3 : failb_exp + 1;
                chk("err_tolB", 32'(err_b),
                    32'(tol_err(it.prod, it.x, 4194303)));
                chk("fail_cnt_sat", 32'(fail_b), failb_exp);
            end
        end
    end

    task automatic push_exp(input logic [22:0] x, input logic [26:0] p,
                            input logic e);
        exp_t it;
        it = '{p, e, x, cyc + 4};
        q.push_back(it);
        qa.push_back(it);
        qb.push_back(it);
    endtask

    task automatic issue(input logic [22:0] x, input logic [26:0] y,
                         input logic [26:0] p, input logic e);
        @(negedge clk_p);
        x_in = x;
        y_in = y;
        ready_in = 1'b1;
        push_exp(x, p, e);
        @(negedge clk_p);
        ready_in = 1'b0;
        repeat (4) @(negedge clk_p);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_prod"}, 32'(prod_out), 0);
        chk({tag, "_err"}, 32'(err_out), 0);
        chk({tag, "_valid"}, 32'(valid_out), 0);
        chk({tag, "_busy"}, 32'(busy_out), 0);
        chk({tag, "_ovr"}, 32'(overrun_out), 0);
        chk({tag, "_pass"}, 32'(pass_cnt), 0);
        chk({tag, "_fail"}, 32'(fail_cnt), 0);
    endtask

    initial begin
        int v0;
        repeat (3) @(negedge clk_p);
        chk_zero("reset");
        reset = 1'b0;

        // 0.25 * 2.0^2 = 1.0
        issue(23'd2097152, 27'd16777216, 27'd8388608, 1'b0);
        // 0.25 * 1.0^2 = 0.25
        issue(23'd2097152, 27'd8388608, 27'd2097152, 1'b1);
        // 0.5 * 1.0^2: diff equals 4194304 exactly
        issue(23'd4194304, 27'd8388608, 27'd4194304, 1'b1);
        // saturation
        issue(23'h7FFFFF, 27'h7FFFFFF, 27'h7FFFFFF, 1'b1);
        // x = 0
        issue(23'd0, 27'd12345678, 27'd0, 1'b1);

        // level held high: one check only
        @(negedge clk_p);
        x_in = 23'd2097152;
        y_in = 27'd16777216;
        ready_in = 1'b1;
        push_exp(x_in, 27'd8388608, 1'b0);
        repeat (20) @(negedge clk_p);
        ready_in = 1'b0;
        repeat (4) @(negedge clk_p);
        chk("ovr_after_hold", 32'(overrun_out), 0);

        // second rise while busy
        @(negedge clk_p);
        x_in = 23'd2097152;
        y_in = 27'd8388608;
        ready_in = 1'b1;
        push_exp(x_in, 27'd2097152, 1'b1);
        @(negedge clk_p);
        ready_in = 1'b0;
        @(negedge clk_p);
        ready_in = 1'b1;
        @(negedge clk_p);
        ready_in = 1'b0;
        repeat (5) @(negedge clk_p);
        chk("overrun_set", 32'(overrun_out), 1);

        // reset lands while the FSM is in MUL2
        @(negedge clk_p);
        x_in = 23'd2097152;
        y_in = 27'd16777216;
        ready_in = 1'b1;
        @(negedge clk_p);
        ready_in = 1'b0;
        @(negedge clk_p);
        reset = 1'b1;
        pass_exp = 0;
        fail_exp = 0;
        failb_exp = 0;
        v0 = vcnt;
        @(negedge clk_p);
        chk_zero("abort");
        reset = 1'b0;
        repeat (6) @(negedge clk_p);
        chk("abort_no_valid", vcnt, v0);

        // fails past the 2-bit counter limit of u_b
        issue(23'd0, 27'd8388608, 27'd0, 1'b1);
        issue(23'd2097152, 27'd8388608, 27'd2097152, 1'b1);
        issue(23'd2097152, 27'd16777216, 27'd8388608, 1'b0);
        issue(23'h7FFFFF, 27'h7FFFFFF, 27'h7FFFFFF, 1'b1);
        issue(23'd0, 27'd1, 27'd0, 1'b1);

        repeat (4) @(negedge clk_p);
        chk("q_drained", q.size(), 0);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
